red_pitaya_dac_softstart: RTL and testbench
===========================================

Name: red_pitaya_dac_softstart

Overview:
Per-channel output conditioning stage between the ASG channel output (signed 14-bit DAC code) and the DAC interface. It ramps the output smoothly from 0 to the live waveform when enabled, and back to 0 when disabled, at a programmable slew rate. This avoids output steps on enable/disable and on reconfiguration. One instance per channel sits directly downstream of each ASG channel.

Parameters:
DW, 14, data width of input/output DAC codes (signed two's complement)
DIVW, 16, width of tick prescaler

Ports:
dac_clk_i  input  1  DAC clock; single clock domain
dac_rst_i  input  1  synchronous reset, active-high
dat_i  input  DW  signed sample from ASG channel, valid every cycle
ena_i  input  1  output enable request (level)
set_step_i  input  DW  unsigned max code change per tick; 0 = jump in one tick
set_div_i  input  DIVW  tick period minus 1 (tick every set_div_i+1 cycles)
set_bypass_i  input  1  1 = dat_o follows dat_i directly, ramp FSM held in IDLE
dat_o  output  DW  signed conditioned sample to DAC
state_o  output  2  FSM state: 0 IDLE, 1 RAMP_UP, 2 TRACK, 3 RAMP_DOWN
busy_o  output  1  high in RAMP_UP or RAMP_DOWN

Behaviour:
- Reset (sync, dac_rst_i=1 at clock edge): dat_o=0, state_o=IDLE, busy_o=0, internal cur=0, div_cnt=0. Reset mid-ramp is immediate: output 0 on the next cycle, no ramp down.
- All outputs are registered. dat_o = cur register.
- Tick: div_cnt counts 0..set_div_i. tick=1 in the cycle div_cnt==set_div_i, then div_cnt wraps to 0. div_cnt is cleared on every state entry into RAMP_UP/RAMP_DOWN, so the first step comes set_div_i+1 cycles after entry. set_div_i=0 gives a tick every cycle. A set_div_i change mid-count: if div_cnt > new value, div_cnt wraps to 0 on the next cycle without ticking.
- Slew step (RAMP_UP/RAMP_DOWN, on tick only):
  - diff = target - cur, computed with DW+1 bits signed.
  - If set_step_i==0 or |diff| <= set_step_i, then cur <= target.
  - Otherwise cur <= cur + step if diff>0, else cur - step.
  - The result always lies between cur and target, so no overflow and no saturation is needed.
- Targets: RAMP_UP target = dat_i sampled in the current cycle (a moving target is tracked). RAMP_DOWN target = 0.
- FSM, evaluated every cycle, priority top-down:
  - set_bypass_i=1: state forced to IDLE, cur <= dat_i (1-cycle latency). On bypass deassert, cur <= 0 the next cycle. The FSM then proceeds from IDLE normally; a step is expected.
  - IDLE: cur <= 0. If ena_i, go to RAMP_UP.
  - RAMP_UP:
    - If !ena_i, go to RAMP_DOWN. cur holds this cycle and the ramp down starts from the current value.
    - Else, on tick, apply the slew step. If that step lands cur on target, go to TRACK.
  - TRACK:
    - cur <= dat_i each cycle (latency 1, no slew limit).
    - If !ena_i, go to RAMP_DOWN. cur holds the last tracked value in this transition cycle.
  - RAMP_DOWN:
    - If ena_i, go to RAMP_UP (re-enable mid-ramp reverses from the current value).
    - Else, on tick, step toward 0. If the step lands on 0, go to IDLE.
    - Entering RAMP_DOWN with cur==0 goes to IDLE on the first tick.
- ena_i toggling every cycle: the FSM alternates RAMP_UP/RAMP_DOWN, div_cnt is re-cleared on each entry, and cur never moves.
- Negative full scale -2^(DW-1): |diff| up to 2^DW-1 fits in DW+1 bits. set_step_i is unsigned and never sign-extended.
- busy_o and state_o update in the same edge as the state register.

Test Plan:
- Reset: drive dat_i=0x1FFF, ena_i=1, pulse dac_rst_i mid-RAMP_UP -> next cycle dat_o=0, state_o=0, busy_o=0.
- Ramp up, constant input: dat_i=1000, step=100, div=3, ena_i 0->1 -> state RAMP_UP; dat_o=100 after 4 cycles, +100 every 4 cycles; after 40 cycles dat_o=1000 and state=TRACK. Then a dat_i change to 1234 appears 1 cycle later.
- Ramp down from negative: TRACK with dat_i=-8192, step=4096, div=0, ena_i->0 -> dat_o -8192 (hold cycle), then -4096, then 0 -> IDLE, busy_o falls with IDLE.
- Reversal: ramp down from 2000 with step=500, div=0; after dat_o=1000 assert ena_i -> RAMP_UP next cycle, resumes at 1000 with no step to 0, and reaches TRACK at 2000 after 2 ticks.
- Edge cases: step=0 with div=9 and dat_i=-500 -> dat_o jumps to -500 exactly 10 cycles after enable. Bypass=1 -> dat_o=dat_i delayed 1 cycle and state_o=IDLE regardless of ena_i.
- Moving target: dat_i sine of amplitude 4000, step=50, div=0 -> no per-cycle change exceeds 50 during RAMP_UP, and TRACK is entered on the first cycle cur reaches the instantaneous dat_i.

Source files
------------

// File: rtl/red_pitaya_dac_softstart.sv
// red_pitaya_dac_softstart: slew-limited ramp of a DAC channel between 0 and the live waveform on enable/disable
module red_pitaya_dac_softstart #(
  parameter int DW   = 14,
  parameter int DIVW = 16
) (
  input  logic            dac_clk_i,
  input  logic            dac_rst_i,
  input  logic [DW-1:0]   dat_i,
  input  logic            ena_i,
  input  logic [DW-1:0]   set_step_i,
  input  logic [DIVW-1:0] set_div_i,
  input  logic            set_bypass_i,
  output logic [DW-1:0]   dat_o,
  output logic [1:0]      state_o,
  output logic            busy_o
);
  typedef enum logic [1:0] {IDLE, RAMP_UP, TRACK, RAMP_DOWN} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   cur_q, cur_d, tgt, slew;
  logic [DIVW-1:0] div_q, div_d;
  logic [DW:0]     diff, adiff;
  logic            busy_q, tick, lands;
  assign tgt   = state_q == RAMP_DOWN ? '0 : dat_i;
  assign diff  = {tgt[DW-1], tgt} - {cur_q[DW-1], cur_q};
  assign adiff = diff[DW] ? -diff : diff;
  assign lands = set_step_i == '0 || adiff <= {1'b0, set_step_i};
  assign slew  = lands ? tgt : diff[DW] ? cur_q - set_step_i : cur_q + set_step_i;
  assign tick  = div_q == set_div_i;
  // Next state, next output code and prescaler; prescaler restarts on every ramp entry
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    if (set_bypass_i) begin
      state_d = IDLE;
      cur_d   = dat_i;
    end else begin
      case (state_q)
        IDLE: begin
          cur_d   = '0;
          state_d = ena_i ? RAMP_UP : IDLE;
        end
        RAMP_UP:
          if (!ena_i) state_d = RAMP_DOWN;
          else if (tick) begin
            cur_d   = slew;
            state_d = lands ? TRACK : RAMP_UP;
          end
        TRACK:
          if (!ena_i) state_d = RAMP_DOWN;
          else cur_d = dat_i;
        RAMP_DOWN:
          if (ena_i) state_d = RAMP_UP;
          else if (tick) begin
            cur_d   = slew;
            state_d = lands ? IDLE : RAMP_DOWN;
          end
        default: state_d = IDLE;
      endcase
    end
    div_d = ((state_d == RAMP_UP || state_d == RAMP_DOWN) && state_d != state_q) ? '0 :
            div_q >= set_div_i ? '0 : div_q + 1'b1;
  end
  // State, output code, prescaler and busy flag registers
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      div_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      div_q   <= div_d;
      busy_q  <= state_d == RAMP_UP || state_d == RAMP_DOWN;
    end
  end
  assign dat_o   = cur_q;
  assign state_o = state_q;
  assign busy_o  = busy_q;
endmodule

// File: tb/tb_red_pitaya_dac_softstart.sv
// tb_red_pitaya_dac_softstart: scoreboard bench for the DAC soft-start stage against an integer reference model
module tb_red_pitaya_dac_softstart;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] dat_i = '0;
  logic        ena_i = 1'b0;
  logic [13:0] step_i = '0;
  logic [15:0] div_i = '0;
  logic        byp_i = 1'b0;
  logic [13:0] dat_o;
  logic [1:0]  state_o;
  logic        busy_o;
  typedef struct {int d; int s; bit b;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ms = 0, mc = 0, mk = 0;
  always #5 clk = ~clk;
  red_pitaya_dac_softstart #(.DW(14), .DIVW(16)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst), .dat_i(dat_i), .ena_i(ena_i),
    .set_step_i(step_i), .set_div_i(div_i), .set_bypass_i(byp_i),
    .dat_o(dat_o), .state_o(state_o), .busy_o(busy_o)
  );
  function automatic int move_to(int c, int t, int s);
    int d = t - c;
    int a = d < 0 ? -d : d;
    if (s == 0 || a <= s) return t;
    return d > 0 ? c + s : c - s;
  endfunction
  task automatic cyc(input bit r, input int d, input bit e, input int st, input int dv, input bit b);
    int ns, nc, tgt, nxt;
    bit tick;
    @(negedge clk);
    rst = r; dat_i = 14'(d); ena_i = e; step_i = 14'(st); div_i = 16'(dv); byp_i = b;
    if (r) begin
      ms = 0; mc = 0; mk = 0;
    end else begin
      tick = mk == dv;
      tgt = ms == 3 ? 0 : d;
      nxt = move_to(mc, tgt, st);
      ns = ms; nc = mc;
      if (b) begin ns = 0; nc = d; end
      else if (ms == 0) begin nc = 0; if (e) ns = 1; end
      else if (ms == 1) begin
        if (!e) ns = 3;
        else if (tick) begin nc = nxt; if (nxt == tgt) ns = 2; end
      end else if (ms == 2) begin
        if (!e) ns = 3; else nc = d;
      end else begin
        if (e) ns = 1;
        else if (tick) begin nc = nxt; if (nxt == 0) ns = 0; end
      end
      if ((ns == 1 || ns == 3) && ns != ms) mk = 0;
      else mk = mk >= dv ? 0 : mk + 1;
      ms = ns; mc = nc;
    end
    exp_q.push_back('{mc, ms, ms == 1 || ms == 3});
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (int'($signed(dat_o)) != e.d || int'(state_o) != e.s || busy_o != e.b) begin
        n_bad++;
        $display("FAIL out @%0t: dat_o=%0d state=%0d busy=%0d, expected dat_o=%0d state=%0d busy=%0d",
                 $time, $signed(dat_o), state_o, busy_o, e.d, e.s, e.b);
      end
    end
  end
  initial begin
    int d, st, dv, k;
    bit e, b, tog;
    int steps[8] = '{0, 1, 7, 100, 1000, 4096, 8191, 16383};
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 8191, 1, 1, 0, 0);
    cyc(1, 8191, 1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 100, 3, 0);
    repeat (45) cyc(0, 1000, 1, 100, 3, 0);
    repeat (3) cyc(0, 1234, 1, 100, 3, 0);
    repeat (10) cyc(0, -8192, 1, 4096, 0, 0);
    repeat (5) cyc(0, -8192, 0, 4096, 0, 0);
    repeat (10) cyc(0, 2000, 1, 500, 0, 0);
    repeat (3) cyc(0, 2000, 0, 500, 0, 0);
    repeat (6) cyc(0, 2000, 1, 500, 0, 0);
    repeat (15) cyc(0, -500, 0, 0, 9, 0);
    repeat (15) cyc(0, -500, 1, 0, 9, 0);
    for (int i = 0; i < 12; i++) cyc(0, int'($urandom_range(16383)) - 8192, 1'($urandom), 50, 2, 1);
    repeat (3) cyc(0, 700, 1, 50, 2, 0);
    repeat (12) cyc(0, 3000, 0, 50, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 3000, 1'(i), 50, 0, 0);
    repeat (20) cyc(0, 0, 0, 50, 0, 0);
    for (int i = 0; i < 400; i++) cyc(0, $rtoi(4000.0 * $sin(6.2831853 * i / 97.0)), 1, 50, 0, 0);
    repeat (100) cyc(0, 0, 0, 50, 0, 0);
    repeat (10) cyc(0, 0, 1, 50, 10, 0);
    repeat (3) cyc(0, 0, 1, 50, 2, 0);
    d = 0; e = 0; b = 0; tog = 0; st = 100; dv = 1;
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(99));
      if (k < 3) d = int'($urandom_range(1)) != 0 ? 8191 : -8192;
      else if (k < 20) d = int'($urandom_range(16383)) - 8192;
      else begin
        d = d + int'($urandom_range(200)) - 100;
        d = d > 8191 ? 8191 : d < -8192 ? -8192 : d;
      end
      if ($urandom_range(29) == 0) e = ~e;
      if ($urandom_range(199) == 0) tog = ~tog;
      if (tog) e = ~e;
      if ($urandom_range(99) == 0) b = ~b;
      if ($urandom_range(39) == 0) st = steps[$urandom_range(7)];
      if ($urandom_range(49) == 0) dv = int'($urandom_range(4));
      cyc($urandom_range(599) == 0, d, e, st, dv, b);
    end
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
